// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: producer latency classes and
// the default forward-to-writeback distance.
package hazard_scoreboard_pkg;

   localparam int unsigned LAT_ALU         = 0;
   localparam int unsigned LAT_LOAD        = 1;
   localparam int unsigned LAT_MUL         = 4;
   localparam int unsigned WB_DIST_DEFAULT = 2;

endpackage

// File: rtl/hazard_reg_counter.sv
// One architectural register's in-flight write tracker: a forwardable
// countdown and a register-file-visible countdown, reload wins over decrement.
module hazard_reg_counter
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] fwd_val_i,
   input  logic [CNT_W-1:0] wb_val_i,
   output logic [CNT_W-1:0] fwd_cnt_o,
   output logic [CNT_W-1:0] wb_cnt_o
);

   logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
   logic [CNT_W-1:0] wb_cnt_q,  wb_cnt_d;

   always_comb begin
      fwd_cnt_d = fwd_cnt_q;
      wb_cnt_d  = wb_cnt_q;
      if (load_i) begin
         fwd_cnt_d = fwd_val_i;
         wb_cnt_d  = wb_val_i;
      end else begin
         // saturating decrement, never wraps below zero
         if (fwd_cnt_q != '0) fwd_cnt_d = fwd_cnt_q - CNT_W'(1);
         if (wb_cnt_q  != '0) wb_cnt_d  = wb_cnt_q  - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fwd_cnt_q <= '0;
         wb_cnt_q  <= '0;
      end else begin
         fwd_cnt_q <= fwd_cnt_d;
         wb_cnt_q  <= wb_cnt_d;
      end
   end

   assign fwd_cnt_o = fwd_cnt_q;
   assign wb_cnt_o  = wb_cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage stall decision from per-register in-flight write countdowns.
// Optional stall cycle counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned REG_W    = 5,
   parameter int unsigned LAT_W    = 3,
   parameter int unsigned WB_DIST  = WB_DIST_DEFAULT,
   parameter int unsigned CNT_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   input  logic                flush,
   input  logic                forward_EN,
   input  logic [REG_W-1:0]    src1_ID,
   input  logic [REG_W-1:0]    src2_ID,
   input  logic                src2_valid,
   input  logic                is_branch,
   input  logic [REG_W-1:0]    dest_ID,
   input  logic                WB_EN_ID,
   input  logic [LAT_W-1:0]    op_lat,
   output logic                hazard_detected,
   output logic [NUM_REGS-1:0] busy_vec
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]         stall_count
`endif
);

   localparam int unsigned CMP_W = CNT_W + 1;

   if (((2 ** CNT_W) - 1) < ((2 ** LAT_W) - 1 + WB_DIST)) begin : g_cnt_w_chk
      $error("hazard_scoreboard: CNT_W too narrow for LAT_W + WB_DIST");
   end
   if (REG_W != $clog2(NUM_REGS)) begin : g_reg_w_chk
      $error("hazard_scoreboard: REG_W must equal clog2(NUM_REGS)");
   end

   logic [CNT_W-1:0] fwd_cnt [NUM_REGS];
   logic [CNT_W-1:0] wb_cnt  [NUM_REGS];
   logic [CNT_W-1:0] fwd_ld_val, wb_ld_val;
   logic             issue;
   logic             use1, use2, fwd_mode, blk1, blk2, waw, hazard;
   logic [CNT_W-1:0] cnt1, cnt2;

   assign fwd_ld_val = CNT_W'(op_lat);
   assign wb_ld_val  = CNT_W'(op_lat) + CNT_W'(WB_DIST);

   // register 0 is hardwired zero and never tracked
   assign fwd_cnt[0]  = '0;
   assign wb_cnt[0]   = '0;
   assign busy_vec[0] = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
      hazard_reg_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .load_i    (issue && WB_EN_ID && (dest_ID == REG_W'(r))),
         .fwd_val_i (fwd_ld_val),
         .wb_val_i  (wb_ld_val),
         .fwd_cnt_o (fwd_cnt[r]),
         .wb_cnt_o  (wb_cnt[r])
      );
      assign busy_vec[r] = (wb_cnt[r] != '0);
   end

   // ID branch compares have no forward path, so they wait for writeback
   always_comb begin
      use1     = (src1_ID != '0);
      use2     = src2_valid && (src2_ID != '0);
      fwd_mode = forward_EN && !is_branch;
      cnt1     = fwd_mode ? fwd_cnt[src1_ID] : wb_cnt[src1_ID];
      cnt2     = fwd_mode ? fwd_cnt[src2_ID] : wb_cnt[src2_ID];
      blk1     = use1 && (cnt1 != '0);
      blk2     = use2 && (cnt2 != '0);
      waw      = WB_EN_ID && (dest_ID != '0) &&
                 ({1'b0, wb_cnt[dest_ID]} > (CMP_W'(op_lat) + CMP_W'(WB_DIST)));
      hazard   = issue_valid && !flush && (blk1 || blk2 || waw);
      issue    = issue_valid && !flush && !hazard;
   end

   assign hazard_detected = hazard;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if (hazard && (stall_count_q != 32'hFFFF_FFFF)) stall_count_d = stall_count_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_count_q <= '0;
      else      stall_count_q <= stall_count_d;
   end

   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal
// expectations, then randomized traffic against an absolute-time ready model.
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   localparam int NR = 32;
   localparam int WBD = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, flush, forward_EN, src2_valid, is_branch, WB_EN_ID;
   logic [4:0]  src1_ID, src2_ID, dest_ID;
   logic [2:0]  op_lat;
   logic        hazard_detected;
   logic [31:0] busy_vec;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_count;
`endif

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk             (clk),
      .rst             (rst),
      .issue_valid     (issue_valid),
      .flush           (flush),
      .forward_EN      (forward_EN),
      .src1_ID         (src1_ID),
      .src2_ID         (src2_ID),
      .src2_valid      (src2_valid),
      .is_branch       (is_branch),
      .dest_ID         (dest_ID),
      .WB_EN_ID        (WB_EN_ID),
      .op_lat          (op_lat),
      .hazard_detected (hazard_detected),
      .busy_vec        (busy_vec)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_count     (stall_count)
`endif
   );

   // Model: absolute cycle at which each register becomes forwardable / readable.
   int fdone [NR];
   int wdone [NR];
   int now;
   int perf_m;
   int n_tests;
   int n_fail;

   function automatic int rem(input int done);
      return (done > now) ? (done - now) : 0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, now, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NR; r++) begin
         fdone[r] = 0;
         wdone[r] = 0;
      end
      perf_m = 0;
   endtask

   // One ID cycle: drive, check at negedge against model (and literal if exp_hz >= 0), advance.
   task automatic cycle(input bit iv, input bit fl, input bit fe, input int s1, input int s2,
                        input bit s2v, input bit br, input int d, input bit we, input int lat,
                        input int exp_hz);
      bit use1, use2, fm, blk, waw, hz;
      logic [31:0] busy_m;
      issue_valid = iv;  flush = fl;  forward_EN = fe;
      src1_ID = 5'(s1);  src2_ID = 5'(s2);  src2_valid = s2v;  is_branch = br;
      dest_ID = 5'(d);   WB_EN_ID = we;     op_lat = 3'(lat);
      @(negedge clk);
      use1 = (s1 != 0);
      use2 = s2v && (s2 != 0);
      fm   = fe && !br;
      blk  = (use1 && ((fm ? rem(fdone[s1]) : rem(wdone[s1])) > 0)) ||
             (use2 && ((fm ? rem(fdone[s2]) : rem(wdone[s2])) > 0));
      waw  = we && (d != 0) && (rem(wdone[d]) > lat + WBD);
      hz   = iv && !fl && (blk || waw);
      busy_m = '0;
      for (int r = 1; r < NR; r++) busy_m[r] = (rem(wdone[r]) > 0);
      check("hazard", 64'(hazard_detected), 64'(hz));
      if (exp_hz >= 0) check("hazard_lit", 64'(hazard_detected), 64'(exp_hz));
      check("busy_vec", 64'(busy_vec), 64'(busy_m));
`ifdef HAZARD_PERF_CNT_EN
      check("stall_count", 64'(stall_count), 64'(perf_m));
`endif
      if (hz) perf_m++;
      if (iv && !fl && !hz && we && d != 0) begin
         fdone[d] = now + 1 + lat;
         wdone[d] = now + 1 + lat + WBD;
      end
      @(posedge clk);
      now++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      n_tests = 0;  n_fail = 0;  now = 0;
      model_reset();
      rst = 1'b0;
      issue_valid = 0; flush = 0; forward_EN = 0; src2_valid = 0; is_branch = 0; WB_EN_ID = 0;
      src1_ID = '0; src2_ID = '0; dest_ID = '0; op_lat = '0;
      #1;
      check("reset_hazard", 64'(hazard_detected), 64'd0);
      check("reset_busy", 64'(busy_vec), 64'd0);
`ifdef HAZARD_PERF_CNT_EN
      check("reset_stall_count", 64'(stall_count), 64'd0);
`endif
      @(posedge clk);
      #1 rst = 1'b1;

      // 1: no forwarding, ALU producer -> two stalls
      cycle(1, 0, 0, 0, 0, 0, 0, 5, 1, LAT_ALU, 0);
      cycle(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      idle(10);

      // 2: forwarding; ALU -> 0 stalls, load -> 1 stall, unused src2 -> 0
      cycle(1, 0, 1, 0, 0, 0, 0, 5, 1, LAT_ALU, 0);
      cycle(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      idle(10);
      cycle(1, 0, 1, 0, 0, 0, 0, 5, 1, LAT_LOAD, 0);
      cycle(1, 0, 1, 0, 5, 1, 0, 0, 0, 0, 1);
      cycle(1, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0);
      idle(10);
      cycle(1, 0, 1, 0, 0, 0, 0, 5, 1, LAT_LOAD, 0);
      cycle(1, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0);
      idle(10);

      // 3: branch compare in ID cannot forward
      cycle(1, 0, 1, 0, 0, 0, 0, 5, 1, LAT_ALU, 0);
      cycle(1, 0, 1, 5, 0, 0, 1, 0, 0, 0, 1);
      cycle(1, 0, 1, 5, 0, 0, 1, 0, 0, 0, 1);
      cycle(1, 0, 1, 5, 0, 0, 1, 0, 0, 0, 0);
      idle(10);

      // 4: WAW behind a multiply; ALU write stalls while wb_cnt is 5, 4, 3
      cycle(1, 0, 1, 0, 0, 0, 0, 7, 1, LAT_MUL, 0);
      idle(1);
      cycle(1, 0, 1, 0, 0, 0, 0, 7, 1, LAT_ALU, 1);
      cycle(1, 0, 1, 0, 0, 0, 0, 7, 1, LAT_ALU, 1);
      cycle(1, 0, 1, 0, 0, 0, 0, 7, 1, LAT_ALU, 1);
      cycle(1, 0, 1, 0, 0, 0, 0, 7, 1, LAT_ALU, 0);
      idle(10);

      // 5: r0 is never tracked; flush suppresses stall and load
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, LAT_MUL, 0);
      cycle(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      check("r0_busy", 64'(busy_vec), 64'd0);
      cycle(1, 0, 0, 0, 0, 0, 0, 5, 1, LAT_ALU, 0);
      cycle(1, 1, 0, 5, 0, 0, 0, 9, 1, LAT_MUL, 0);
      check("flush_no_load", 64'(busy_vec[9]), 64'd0);
      cycle(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      idle(10);

      // 6: reset asserted in the middle of a stall
      cycle(1, 0, 0, 0, 0, 0, 0, 5, 1, LAT_MUL, 0);
      cycle(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1);
`ifdef HAZARD_PERF_CNT_EN
      check("stall_total", 64'(stall_count), 64'(perf_m));
      check("stall_total_lit", 64'(stall_count), 64'd11);
`endif
      check("pre_reset_hazard", 64'(hazard_detected), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("rst_hazard", 64'(hazard_detected), 64'd0);
      check("rst_busy", 64'(busy_vec), 64'd0);
`ifdef HAZARD_PERF_CNT_EN
      check("rst_stall_count", 64'(stall_count), 64'd0);
`endif
      model_reset();
      @(posedge clk);
      now++;
      #1 rst = 1'b1;
      idle(2);

      // randomized traffic over a small register window to provoke hazards
      for (int i = 0; i < 800; i++) begin
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, 1'($urandom),
               $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 4) == 0,
               $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
